// File: rtl/soc_obi_arbiter.sv
// Round-robin OBI arbiter: N requestors share one OBI target, with address-phase
// lock, an outstanding-transaction limit and in-order response routing.
module soc_obi_arbiter #(
  parameter int unsigned NUM_MASTERS     = 2,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [NUM_MASTERS-1:0]                      m_req_i,
  output logic [NUM_MASTERS-1:0]                      m_gnt_o,
  input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]      m_addr_i,
  input  logic [NUM_MASTERS-1:0]                      m_we_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]    m_be_i,
  input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_wdata_i,
  output logic [NUM_MASTERS-1:0]                      m_rvalid_o,
  output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]      m_rdata_o,
  output logic                                        s_req_o,
  input  logic                                        s_gnt_i,
  output logic [ADDR_WIDTH-1:0]                       s_addr_o,
  output logic                                        s_we_o,
  output logic [DATA_WIDTH/8-1:0]                     s_be_o,
  output logic [DATA_WIDTH-1:0]                       s_wdata_o,
  input  logic                                        s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                       s_rdata_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]        outstanding_o,
  output logic                                        err_o
);

  localparam int unsigned IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] rr_ptr;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] id_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             err_q;

  logic [IDX_W-1:0] rr_winner;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] rr_next;
  logic [IDX_W-1:0] head;
  logic             found;
  int unsigned      cand;
  logic             handshake;
  logic             fifo_empty;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == MAX_OUTSTANDING - 1) ? '0 : p + PTR_W'(1);
  endfunction

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    rr_winner = rr_ptr;
    found     = 1'b0;
    cand      = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      cand = 32'(rr_ptr) + i;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && m_req_i[IDX_W'(cand)]) begin
        rr_winner = IDX_W'(cand);
        found     = 1'b1;
      end
    end
  end

  // A stalled address phase keeps its owner until the target accepts it.
  assign winner     = lock_q ? lock_idx : rr_winner;
  assign rr_next    = (winner == IDX_W'(NUM_MASTERS - 1)) ? '0 : winner + IDX_W'(1);
  assign s_req_o    = (|m_req_i) && (count < CNT_W'(MAX_OUTSTANDING));
  assign handshake  = s_req_o && s_gnt_i && !reset_i;
  assign fifo_empty = (count == '0);
  assign pop        = s_rvalid_i && !fifo_empty && !reset_i;
  assign head       = id_mem[rd_ptr];

  assign s_addr_o  = m_addr_i[winner];
  assign s_we_o    = m_we_i[winner];
  assign s_be_o    = m_be_i[winner];
  assign s_wdata_o = m_wdata_i[winner];

  // Grant and response routing; unselected rdata lanes stay zero.
  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    if (handshake) m_gnt_o[winner] = 1'b1;
    if (pop) begin
      m_rvalid_o[head] = 1'b1;
      m_rdata_o[head]  = s_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_ptr   <= '0;
      lock_q   <= 1'b0;
      lock_idx <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      err_q    <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr <= rr_next;
        lock_q <= 1'b0;
        wr_ptr <= ptr_inc(wr_ptr);
      end else if (s_req_o) begin
        lock_q   <= 1'b1;
        lock_idx <= winner;
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({handshake, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (s_rvalid_i && fifo_empty) err_q <= 1'b1;
    end
  end

  // ID storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk_i) begin
    if (handshake) id_mem[wr_ptr] <= winner;
  end

  assign outstanding_o = count;
  assign err_o         = err_q;

endmodule

// File: tb/tb_soc_obi_arbiter.sv
// Directed bench for soc_obi_arbiter with three masters and two outstanding slots.
module tb_soc_obi_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MO = 2;

  logic                        clk = 1'b0;
  logic                        reset_i;
  logic [N-1:0]                m_req;
  logic [N-1:0]                m_gnt;
  logic [N-1:0][AW-1:0]        m_addr;
  logic [N-1:0]                m_we;
  logic [N-1:0][DW/8-1:0]      m_be;
  logic [N-1:0][DW-1:0]        m_wdata;
  logic [N-1:0]                m_rvalid;
  logic [N-1:0][DW-1:0]        m_rdata;
  logic                        s_req;
  logic                        s_gnt;
  logic [AW-1:0]               s_addr;
  logic                        s_we;
  logic [DW/8-1:0]             s_be;
  logic [DW-1:0]               s_wdata;
  logic                        s_rvalid;
  logic [DW-1:0]               s_rdata;
  logic [$clog2(MO+1)-1:0]     outstanding;
  logic                        err;

  int n_chk  = 0;
  int n_fail = 0;

  soc_obi_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_req_i(m_req), .m_gnt_o(m_gnt), .m_addr_i(m_addr), .m_we_i(m_we),
    .m_be_i(m_be), .m_wdata_i(m_wdata), .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata),
    .s_req_o(s_req), .s_gnt_i(s_gnt), .s_addr_o(s_addr), .s_we_o(s_we),
    .s_be_o(s_be), .s_wdata_o(s_wdata), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, input logic [N-1:0] req, input logic gnt,
                       input logic rv, input logic [DW-1:0] rd);
    @(negedge clk);
    reset_i  = rst;
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_rdata  = rd;
    #1;
  endtask

  function automatic logic [N-1:0][DW-1:0] rdv(input int idx, input logic [DW-1:0] d);
    logic [N-1:0][DW-1:0] v;
    v      = '0;
    v[idx] = d;
    return v;
  endfunction

  initial begin
    reset_i  = 1'b1;
    m_req    = '0;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_rdata  = '0;
    m_addr[0] = 32'h1000_0A00; m_addr[1] = 32'h2000_0B10; m_addr[2] = 32'h3000_0C20;
    m_we      = 3'b010;
    m_be[0]   = 4'hF; m_be[1] = 4'h3; m_be[2] = 4'hC;
    m_wdata[0] = 32'hAAAA_0000; m_wdata[1] = 32'hBBBB_1111; m_wdata[2] = 32'hCCCC_2222;

    // Reset: no grants or responses even with target activity.
    drive(1'b1, 3'b000, 1'b1, 1'b1, 32'h0000_0BAD);
    chk("rst_gnt",    128'(m_gnt),    128'(3'b000));
    chk("rst_rvalid", 128'(m_rvalid), 128'(3'b000));
    chk("rst_rdata",  128'(m_rdata),  128'(0));
    chk("rst_sreq",   128'(s_req),    128'(1'b0));
    drive(1'b1, 3'b011, 1'b1, 1'b0, 32'h0);
    chk("rst_sreq_req", 128'(s_req),      128'(1'b1));
    chk("rst_gnt2",     128'(m_gnt),      128'(3'b000));
    chk("rst_outst",    128'(outstanding), 128'(2'd0));
    chk("rst_err",      128'(err),        128'(1'b0));

    // Unsolicited response sets the sticky error.
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("err_rvalid", 128'(m_rvalid), 128'(3'b000));
    chk("err_rdata",  128'(m_rdata),  128'(0));
    chk("err_sreq",   128'(s_req),    128'(1'b0));
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_set",    128'(err),         128'(1'b1));
    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_hold",   128'(err),         128'(1'b1));
    chk("err_outst",  128'(outstanding), 128'(2'd0));
    drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0);
    chk("err_hold2",  128'(err),         128'(1'b1));

    // Two masters streaming: grants alternate, responses follow grants.
    drive(1'b0, 3'b011, 1'b1, 1'b0, 32'h0);
    chk("err_clr",  128'(err),    128'(1'b0));
    chk("rr_a_gnt", 128'(m_gnt),  128'(3'b001));
    chk("rr_a_adr", 128'(s_addr), 128'(32'h1000_0A00));
    chk("rr_a_out", 128'(outstanding), 128'(2'd0));
    drive(1'b0, 3'b011, 1'b1, 1'b1, 32'h0000_00D1);
    chk("rr_b_gnt", 128'(m_gnt),    128'(3'b010));
    chk("rr_b_rv",  128'(m_rvalid), 128'(3'b001));
    chk("rr_b_rd",  128'(m_rdata),  128'(rdv(0, 32'h0000_00D1)));
    chk("rr_b_out", 128'(outstanding), 128'(2'd1));
    chk("rr_b_adr", 128'(s_addr),   128'(32'h2000_0B10));
    chk("rr_b_we",  128'(s_we),     128'(1'b1));
    drive(1'b0, 3'b011, 1'b1, 1'b1, 32'h0000_00D2);
    chk("rr_c_gnt", 128'(m_gnt),    128'(3'b001));
    chk("rr_c_rv",  128'(m_rvalid), 128'(3'b010));
    chk("rr_c_rd",  128'(m_rdata),  128'(rdv(1, 32'h0000_00D2)));
    chk("rr_c_out", 128'(outstanding), 128'(2'd1));
    drive(1'b0, 3'b011, 1'b1, 1'b1, 32'h0000_00D3);
    chk("rr_d_gnt", 128'(m_gnt),    128'(3'b010));
    chk("rr_d_rd",  128'(m_rdata),  128'(rdv(0, 32'h0000_00D3)));
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_00D4);
    chk("rr_e_gnt", 128'(m_gnt),    128'(3'b000));
    chk("rr_e_rd",  128'(m_rdata),  128'(rdv(1, 32'h0000_00D4)));
    chk("rr_e_out", 128'(outstanding), 128'(2'd1));

    // Single M0 transaction moves the pointer to 1.
    drive(1'b0, 3'b001, 1'b1, 1'b0, 32'h0);
    chk("p_out", 128'(outstanding), 128'(2'd0));
    chk("p_gnt", 128'(m_gnt),       128'(3'b001));
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_00D5);
    chk("q_rv",  128'(m_rvalid),    128'(3'b001));

    // Address-phase lock: M0 holds the bus through three stalled cycles.
    drive(1'b0, 3'b001, 1'b0, 1'b0, 32'h0);
    chk("lk1_sreq", 128'(s_req),  128'(1'b1));
    chk("lk1_adr",  128'(s_addr), 128'(32'h1000_0A00));
    chk("lk1_gnt",  128'(m_gnt),  128'(3'b000));
    drive(1'b0, 3'b011, 1'b0, 1'b0, 32'h0);
    chk("lk2_adr",  128'(s_addr), 128'(32'h1000_0A00));
    chk("lk2_be",   128'(s_be),   128'(4'hF));
    chk("lk2_gnt",  128'(m_gnt),  128'(3'b000));
    drive(1'b0, 3'b011, 1'b0, 1'b0, 32'h0);
    chk("lk3_adr",  128'(s_addr),  128'(32'h1000_0A00));
    chk("lk3_wd",   128'(s_wdata), 128'(32'hAAAA_0000));
    drive(1'b0, 3'b011, 1'b1, 1'b0, 32'h0);
    chk("lk4_adr",  128'(s_addr), 128'(32'h1000_0A00));
    chk("lk4_gnt",  128'(m_gnt),  128'(3'b001));
    drive(1'b0, 3'b010, 1'b1, 1'b0, 32'h0);
    chk("lk5_gnt",  128'(m_gnt),   128'(3'b010));
    chk("lk5_adr",  128'(s_addr),  128'(32'h2000_0B10));
    chk("lk5_wd",   128'(s_wdata), 128'(32'hBBBB_1111));
    chk("lk5_out",  128'(outstanding), 128'(2'd1));

    // Full: third request stalls until a response frees a slot.
    drive(1'b0, 3'b100, 1'b1, 1'b0, 32'h0);
    chk("full_sreq", 128'(s_req),       128'(1'b0));
    chk("full_gnt",  128'(m_gnt),       128'(3'b000));
    chk("full_out",  128'(outstanding), 128'(2'd2));
    drive(1'b0, 3'b100, 1'b1, 1'b1, 32'h0000_00D6);
    chk("full_sreq2", 128'(s_req),   128'(1'b0));
    chk("full_rv",    128'(m_rvalid), 128'(3'b001));
    chk("full_rd",    128'(m_rdata),  128'(rdv(0, 32'h0000_00D6)));
    drive(1'b0, 3'b100, 1'b1, 1'b0, 32'h0);
    chk("free_out",  128'(outstanding), 128'(2'd1));
    chk("free_gnt",  128'(m_gnt),       128'(3'b100));
    chk("free_adr",  128'(s_addr),      128'(32'h3000_0C20));

    // Same-cycle push and pop at count 1: response goes to the older ID.
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_00D7);
    chk("pp0_rv",  128'(m_rvalid),    128'(3'b010));
    chk("pp0_out", 128'(outstanding), 128'(2'd2));
    drive(1'b0, 3'b001, 1'b1, 1'b1, 32'h0000_00D8);
    chk("pp_out",  128'(outstanding), 128'(2'd1));
    chk("pp_gnt",  128'(m_gnt),       128'(3'b001));
    chk("pp_rd",   128'(m_rdata),     128'(rdv(2, 32'h0000_00D8)));
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_00D9);
    chk("pp2_out", 128'(outstanding), 128'(2'd1));
    chk("pp2_rd",  128'(m_rdata),     128'(rdv(0, 32'h0000_00D9)));

    // Three masters requesting: rotation 1,2, then 0 after a slot frees.
    drive(1'b0, 3'b111, 1'b1, 1'b0, 32'h0);
    chk("r3_out0", 128'(outstanding), 128'(2'd0));
    chk("r3_g1",   128'(m_gnt),       128'(3'b010));
    drive(1'b0, 3'b111, 1'b1, 1'b0, 32'h0);
    chk("r3_g2",   128'(m_gnt),       128'(3'b100));
    drive(1'b0, 3'b111, 1'b1, 1'b1, 32'h0000_00DA);
    chk("r3_full", 128'(m_gnt),       128'(3'b000));
    chk("r3_rd",   128'(m_rdata),     128'(rdv(1, 32'h0000_00DA)));
    drive(1'b0, 3'b111, 1'b1, 1'b0, 32'h0);
    chk("r3_g0",   128'(m_gnt),       128'(3'b001));

    // Reset with two in flight discards them and restarts at master 0.
    drive(1'b1, 3'b111, 1'b1, 1'b0, 32'h0);
    chk("mr_out2", 128'(outstanding), 128'(2'd2));
    chk("mr_gnt",  128'(m_gnt),       128'(3'b000));
    drive(1'b0, 3'b000, 1'b0, 1'b1, 32'h0000_00DB);
    chk("mr_out0", 128'(outstanding), 128'(2'd0));
    chk("mr_rv",   128'(m_rvalid),    128'(3'b000));
    chk("mr_err0", 128'(err),         128'(1'b0));
    drive(1'b0, 3'b111, 1'b1, 1'b0, 32'h0);
    chk("mr_err1", 128'(err),         128'(1'b1));
    chk("mr_g0",   128'(m_gnt),       128'(3'b001));
    chk("mr_adr",  128'(s_addr),      128'(32'h1000_0A00));

    drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
